uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 87, meaning clk_i cycles per bit (clk_i frequency / baud rate), legal range 4..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame, legal range 5..9.
REQ-003 The block SHALL have parameter PARITY_EN, default 0, meaning 1 = one parity bit follows the data bits.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity and 0 = even parity; it is ignored when PARITY_EN=0.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal values 1 or 2.
REQ-006 clk_i input 1: sole clock; all logic on its rising edge.
REQ-007 rst_ni input 1: reset, asynchronous, active-low.
REQ-008 rx_i input 1: serial line, asynchronous to clk_i, idle high.
REQ-009 rx_dv_o output 1: frame-complete strobe, one cycle wide.
REQ-010 data_o output DATA_BITS: last received payload, LSB = first data bit on line.
REQ-011 parity_err_o output 1: parity mismatch on last frame.
REQ-012 frame_err_o output 1: a stop bit sampled low on last frame.
REQ-013 busy_o output 1: high whenever the FSM is not in IDLE.

Function
REQ-014 rx_i SHALL pass through a two-flop synchronizer; all FSM decisions use the second flop (rx_s), so latency from rx_i to rx_s is 2 cycles.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-016 The bit-timing counter SHALL be $clog2(CLKS_PER_BIT) bits wide and clear on every state transition and after every sample.
REQ-017 IDLE: on rx_s=0, go to START and clear the counter.
REQ-018 START: after CLKS_PER_BIT/2 cycles (floor), sample rx_s; if 0, go to DATA, else return to IDLE with no strobe (glitch reject).
REQ-019 DATA: sample rx_s every CLKS_PER_BIT cycles into a shift register, LSB first, with bit index 0..DATA_BITS-1; after the last bit, go to PARITY if PARITY_EN=1, else to STOP.
REQ-020 PARITY: after CLKS_PER_BIT cycles, sample the parity bit; the error condition is (XOR of data bits XOR parity bit) != PARITY_ODD.
REQ-021 STOP: sample STOP_BITS bits at CLKS_PER_BIT spacing; frame error if any stop sample is 0.
REQ-022 On the final stop sample cycle+1, the block SHALL pulse rx_dv_o for exactly one cycle and update data_o, parity_err_o and frame_err_o in that same cycle.
REQ-023 After the strobe, the FSM SHALL go to IDLE if the final stop sample was 1, else to WAIT_HIGH.
REQ-024 WAIT_HIGH (break or line held low) SHALL remain until rx_s=1, then go to IDLE; no new start is accepted while in WAIT_HIGH.
REQ-025 data_o and both error flags SHALL hold their values between strobes and change only on a strobe.
REQ-026 parity_err_o SHALL be 0 whenever PARITY_EN=0.
REQ-027 A frame that starts immediately after a stop bit (no idle gap) SHALL be received correctly: the return to IDLE occurs mid-stop-bit, so the next falling edge is detected.
REQ-028 rx_dv_o SHALL never assert for a start pulse shorter than CLKS_PER_BIT/2 cycles.
REQ-029 Frame length SHALL be 1 + DATA_BITS + PARITY_EN + STOP_BITS bit times, and the strobe SHALL occur at a fixed offset of 2 + CLKS_PER_BIT/2 + (frame length - 1)*CLKS_PER_BIT + 1 cycles after the rx_i falling edge is first registered.

Reset
REQ-030 While rst_ni=0, the block SHALL set state=IDLE, counter=0, bit index=0, shift register=0, rx_dv_o=0, data_o=0, parity_err_o=0, frame_err_o=0, busy_o=0, and both synchronizer flops=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no strobe; after release, the remaining bits SHALL not produce a strobe unless a valid start (low at half-bit) is seen.

Verification
REQ-032 Defaults with CLKS_PER_BIT=16: send 0xA5 with 1 stop -> one rx_dv_o pulse, data_o=0xA5, both error flags 0, strobe at the REQ-029 offset.
REQ-033 PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 -> parity_err_o=0; resend with parity bit 0 -> parity_err_o=1 and data_o=0x07.
REQ-034 STOP_BITS=2: send 0x3C with second stop bit low -> frame_err_o=1; then hold the line low for 3 frames -> exactly one strobe, busy_o stays high until the line goes high.
REQ-035 Send a 5-cycle low glitch -> no strobe and busy_o returns low; then back-to-back frames 0x00 and 0xFF with no gap -> two strobes with values 0x00 and 0xFF.
REQ-036 DATA_BITS=9: send 0x1AB -> data_o=0x1AB.
REQ-037 Reset mid-frame: assert rst_ni low at data bit 3 of 0x55 -> all outputs 0 and no strobe for that frame; the next clean frame 0x12 -> data_o=0x12.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, mid-bit sampling,
// optional parity, 1 or 2 stop bits, break/line-low recovery.
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   output logic                 rx_dv_o,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 busy_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]    C_LAST = 4'(DATA_BITS - 1);
   localparam logic          L_ODD  = (PARITY_ODD != 0);
   localparam logic          L_PEN  = (PARITY_EN != 0);
   localparam logic          L_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 r_sync1;
   logic                 r_sync2;
   logic [CW-1:0]        r_cnt;
   logic [3:0]           r_bit;
   logic                 r_stop_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bad;
   logic                 r_stop_bad;
   logic                 r_fin;
   logic                 w_rx_s;
   logic                 w_half;
   logic                 w_full;
   logic                 w_last_stop;
   logic                 w_sample;

   assign w_rx_s      = r_sync2;
   assign w_half      = (r_cnt == C_HALF);
   assign w_full      = (r_cnt == C_FULL);
   assign w_last_stop = (r_stop_idx == L_STOP);
   assign w_sample    = ((r_state == S_START) && w_half) ||
                        ((r_state == S_DATA)   && w_full) ||
                        ((r_state == S_PARITY) && w_full) ||
                        ((r_state == S_STOP)   && w_full);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx_i;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (!w_rx_s) w_next = S_START;
         S_START:     if (w_half) w_next = w_rx_s ? S_IDLE : S_DATA;
         S_DATA:      if (w_full && (r_bit == C_LAST))
                         w_next = L_PEN ? S_PARITY : S_STOP;
         S_PARITY:    if (w_full) w_next = S_STOP;
         // Leaving mid-stop-bit lets a back-to-back start edge be seen
         S_STOP:      if (w_full && w_last_stop)
                         w_next = w_rx_s ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH: if (w_rx_s) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (r_state != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if ((r_state == S_IDLE) || (r_state == S_WAIT_HIGH) ||
                   (w_next != r_state) || w_sample) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_bit        <= '0;
         r_stop_idx   <= 1'b0;
         r_shift      <= '0;
         r_par_bad    <= 1'b0;
         r_stop_bad   <= 1'b0;
         r_fin        <= 1'b0;
         rx_dv_o      <= 1'b0;
         data_o       <= '0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         r_fin   <= 1'b0;
         rx_dv_o <= r_fin;
         if (r_state == S_START) begin
            r_bit      <= '0;
            r_stop_idx <= 1'b0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
         end
         if ((r_state == S_DATA) && w_full) begin
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit   <= r_bit + 4'd1;
         end
         if ((r_state == S_PARITY) && w_full) begin
            r_par_bad <= ((^r_shift) ^ w_rx_s) != L_ODD;
         end
         if ((r_state == S_STOP) && w_full) begin
            if (!w_rx_s) r_stop_bad <= 1'b1;
            r_stop_idx <= r_stop_idx + 1'b1;
            if (w_last_stop) r_fin <= 1'b1;
         end
         // Results publish one cycle after the final stop sample
         if (r_fin) begin
            data_o       <= r_shift;
            parity_err_o <= r_par_bad;
            frame_err_o  <= r_stop_bad;
         end
      end
   end

endmodule
